muldiv_sched: RTL and testbench

- Sequencing controller for the HI/LO multiply/divide resource in the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a fixed-latency multiply or a 1-bit/cycle restoring divide.
- Owns the HI/LO registers.
- Generates the stall request that the hazard unit ORs into Stall_PC/Stall_IF_ID/Flush_ID_EX while an HI/LO-dependent instruction sits in ID.

---
 rtl/muldiv_sched.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 1-bit/cycle restoring divide, hazard stall.
// Define MD_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (6..9).
module muldiv_sched #(
    parameter int unsigned MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam logic [3:0] OpMult  = 4'd0;
    localparam logic [3:0] OpMultu = 4'd1;
    localparam logic [3:0] OpDiv   = 4'd2;
    localparam logic [3:0] OpDivu  = 4'd3;
    localparam logic [3:0] OpMthi  = 4'd4;
    localparam logic [3:0] OpMtlo  = 4'd5;
`ifdef MD_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd6;
    localparam logic [3:0] OpMaddu = 4'd7;
    localparam logic [3:0] OpMsub  = 4'd8;
    localparam logic [3:0] OpMsubu = 4'd9;
`endif

    localparam logic [4:0] CntMul = 5'(MUL_LAT - 1);
    localparam logic [4:0] CntDiv = 5'd31;

    typedef enum logic [1:0] {StIdle, StMulWait, StDivIter, StDivFix} state_e;
    typedef enum logic [1:0] {AccNone, AccAdd, AccSub} acc_e;

    state_e      state_q, state_d;
    acc_e        acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Op decode
    logic is_mul, mul_signed, is_div, div_signed;
    acc_e acc_mode;

    always_comb begin
        is_mul     = 1'b0;
        mul_signed = 1'b0;
        is_div     = 1'b0;
        div_signed = 1'b0;
        acc_mode   = AccNone;
        case (op)
            OpMult:  begin is_mul = 1'b1; mul_signed = 1'b1; end
            OpMultu: is_mul = 1'b1;
            OpDiv:   begin is_div = 1'b1; div_signed = 1'b1; end
            OpDivu:  is_div = 1'b1;
`ifdef MD_MADD_EN
            OpMadd:  begin is_mul = 1'b1; mul_signed = 1'b1; acc_mode = AccAdd; end
            OpMaddu: begin is_mul = 1'b1; acc_mode = AccAdd; end
            OpMsub:  begin is_mul = 1'b1; mul_signed = 1'b1; acc_mode = AccSub; end
            OpMsubu: begin is_mul = 1'b1; acc_mode = AccSub; end
`endif
            default: ;
        endcase
    end

    // Sign-extending to 64 bits makes the truncated 64-bit product exact for both signednesses.
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag;

    always_comb begin
        a_ext = {{32{mul_signed & a[31]}}, a};
        b_ext = {{32{mul_signed & b[31]}}, b};
        prod  = a_ext * b_ext;
        a_mag = (div_signed & a[31]) ? (32'd0 - a) : a;
        b_mag = (div_signed & b[31]) ? (32'd0 - b) : b;
    end

    logic [32:0] rem_sh;
    logic [63:0] hilo;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rem_sh    = {rem_q, quo_q[31]};
        hilo      = {hi_q, lo_q};

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_mul) begin
                        prod_d  = prod;
                        acc_d   = acc_mode;
                        cnt_d   = CntMul;
                        state_d = StMulWait;
                    end else if (is_div) begin
                        if (b == 32'd0) begin
                            // Divide by zero: skip iteration, DIV_FIX writes the fixed result.
                            quo_d     = 32'hFFFF_FFFF;
                            rem_d     = a;
                            quo_neg_d = 1'b0;
                            rem_neg_d = 1'b0;
                            state_d   = StDivFix;
                        end else begin
                            quo_d     = a_mag;
                            rem_d     = 32'd0;
                            dvs_d     = b_mag;
                            quo_neg_d = div_signed & (a[31] ^ b[31]);
                            rem_neg_d = div_signed & a[31];
                            cnt_d     = CntDiv;
                            state_d   = StDivIter;
                        end
                    end else if (op == OpMthi) begin
                        hi_d = a;
                    end else if (op == OpMtlo) begin
                        lo_d = a;
                    end
                end
            end
            StMulWait: begin
                if (cnt_q == 5'd0) begin
                    case (acc_q)
                        AccAdd:  {hi_d, lo_d} = hilo + prod_q;
                        AccSub:  {hi_d, lo_d} = hilo - prod_q;
                        default: {hi_d, lo_d} = prod_q;
                    endcase
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StDivIter: begin
                // Remainder stays below the divisor, so the shifted value fits in 33 bits.
                if (rem_sh >= {1'b0, dvs_q}) begin
                    rem_d = 32'(rem_sh - {1'b0, dvs_q});
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = StDivFix;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StDivFix: begin
                lo_d    = quo_neg_q ? (32'd0 - quo_q) : quo_q;
                hi_d    = rem_neg_q ? (32'd0 - rem_q) : rem_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= AccNone;
            cnt_q     <= 5'd0;
            prod_q    <= 64'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != StIdle);
    assign stall_md = md_use_d & (busy | (start & (is_mul | is_div)));

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed and random ops against an arithmetic HI/LO model.
// Honours MD_MADD_EN the same way as the design.
module tb_muldiv_sched;

    localparam int unsigned L = 5;

    logic        clk = 1'b0;
    logic        rst_n, start, md_use_d;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, stall_md;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] hi_m, lo_m;

    muldiv_sched #(.MUL_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .md_use_d(md_use_d), .hi(hi), .lo(lo), .busy(busy), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic bit engine_op(input logic [3:0] o);
`ifdef MD_MADD_EN
        return (o <= 4'd3) || (o >= 4'd6 && o <= 4'd9);
`else
        return (o <= 4'd3);
`endif
    endfunction

    // Reference: HI/LO outcome and busy length computed straight from the arithmetic rules.
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        longint sp;
        logic [63:0] up, acc;
        int sx, sy;
        sp  = longint'($signed(x)) * longint'($signed(y));
        up  = {32'd0, x} * {32'd0, y};
        acc = {hi_m, lo_m};
        sx  = x;
        sy  = y;
        lat = 0;
        case (o)
            4'd0: begin {hi_m, lo_m} = sp; lat = L; end
            4'd1: begin {hi_m, lo_m} = up; lat = L; end
            4'd2, 4'd3: begin
                if (y == 32'd0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = x; lat = 1;
                end else begin
                    lat = 33;
                    if (o == 4'd3) begin
                        lo_m = x / y; hi_m = x % y;
                    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        lo_m = 32'h8000_0000; hi_m = 32'd0;
                    end else begin
                        lo_m = sx / sy; hi_m = sx % sy;
                    end
                end
            end
            4'd4: hi_m = x;
            4'd5: lo_m = x;
`ifdef MD_MADD_EN
            4'd6: begin {hi_m, lo_m} = acc + 64'(sp); lat = L; end
            4'd7: begin {hi_m, lo_m} = acc + up; lat = L; end
            4'd8: begin {hi_m, lo_m} = acc - 64'(sp); lat = L; end
            4'd9: begin {hi_m, lo_m} = acc - up; lat = L; end
`endif
            default: ;
        endcase
    endtask

    // Issue one op in EX (called just after a negedge) and follow it to completion.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic use_d);
        int lat;
        start = 1'b1; op = o; a = x; b = y; md_use_d = use_d;
        #1;
        check1("stall_start_term", stall_md, use_d & engine_op(o));
        model(o, x, y, lat);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        #1;
        for (int i = 0; i < lat; i++) begin
            check1("busy_during", busy, 1'b1);
            check1("stall_during", stall_md, use_d);
            step();
        end
        check1("busy_done", busy, 1'b0);
        check1("stall_done", stall_md, 1'b0);
        check32("hi", hi, hi_m);
        check32("lo", lo, lo_m);
    endtask

    initial begin
        int lat;
        logic [3:0]  ro;
        logic [31:0] rx, ry;
        rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0; md_use_d = 1'b0;
        hi_m = '0; lo_m = '0;
        step();
        step();
        rst_n = 1'b1;
        md_use_d = 1'b1;
        #1;
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_stall", stall_md, 1'b0);

        // Directed cases
        run_op(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        check32("mult_hi_const", hi, 32'hFFFF_FFFF);
        check32("mult_lo_const", lo, 32'hFFFF_FFFA);
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check32("multu_hi_const", hi, 32'd2);
        run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        check32("div_lo_const", lo, 32'hFFFF_FFFD);
        check32("div_hi_const", hi, 32'hFFFF_FFFF);
        run_op(4'd3, 32'd7, 32'd0, 1'b1);
        check32("divu0_hi_const", hi, 32'd7);
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check32("div_ovf_lo_const", lo, 32'h8000_0000);
        run_op(4'd2, 32'h1234_5678, 32'd0, 1'b0);
        run_op(4'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
        run_op(4'd5, 32'hCAFE_F00D, 32'd0, 1'b1);
        run_op(4'd12, 32'h1111_1111, 32'd5, 1'b1);
        run_op(4'd6, 32'd3, 32'd4, 1'b1);

        // Second start while busy must be ignored
        start = 1'b1; op = 4'd0; a = 32'd1000; b = 32'hFFFF_FFF0; md_use_d = 1'b0;
        model(4'd0, 32'd1000, 32'hFFFF_FFF0, lat);
        step();
        op = 4'd5; a = 32'h5555_5555;
        step();
        op = 4'd3; b = 32'd7;
        step();
        start = 1'b0;
        repeat (L) step();
        check1("ignored_busy", busy, 1'b0);
        check32("ignored_hi", hi, hi_m);
        check32("ignored_lo", lo, lo_m);

        // Reset during cycle 10 of a DIV aborts it
        start = 1'b1; op = 4'd2; a = 32'd100; b = 32'd3;
        step();
        start = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hi_m = '0; lo_m = '0;
        #1;
        check1("rst_mid_busy", busy, 1'b0);
        check32("rst_mid_hi", hi, 32'd0);
        check32("rst_mid_lo", lo, 32'd0);
        repeat (30) step();
        check32("rst_abort_hi", hi, 32'd0);
        check32("rst_abort_lo", lo, 32'd0);
        run_op(4'd3, 32'd9, 32'd4, 1'b1);
        check32("divu_9_4_lo", lo, 32'd2);
        check32("divu_9_4_hi", hi, 32'd1);

`ifdef MD_MADD_EN
        run_op(4'd4, 32'd0, 32'd0, 1'b0);
        run_op(4'd5, 32'd10, 32'd0, 1'b0);
        run_op(4'd6, 32'd3, 32'd4, 1'b1);
        check32("madd_lo_const", lo, 32'd22);
        check32("madd_hi_const", hi, 32'd0);
        run_op(4'd8, 32'd1, 32'd23, 1'b1);
        check32("msub_lo_const", lo, 32'hFFFF_FFFF);
        check32("msub_hi_const", hi, 32'hFFFF_FFFF);
`endif

        // Random ops
        for (int k = 0; k < 60; k++) begin
            ro = 4'($urandom_range(0, 15));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 40)) - 32'd20;
            if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 10)) - 32'd5;
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            run_op(ro, rx, ry, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
